// File: rtl/mod_counter_if.sv
// Control and status bundle for mod_counter.
// The counter is the slave and the controlling block is the master.
interface mod_counter_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
);
  logic                  set;
  logic [WIDTH-1:0]      d_in;
  logic                  en;
  logic                  dir;
  logic                  sat;
  logic [WIDTH-1:0]      limit;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      cmp_val;
  logic                  clr_ovf;
  logic [WIDTH-1:0]      q_out;
  logic                  tc;
  logic                  cmp_match;
  logic                  ovf;

  modport master (
    output set, d_in, en, dir, sat, limit, prescale, cmp_val, clr_ovf,
    input  q_out, tc, cmp_match, ovf
  );

  modport slave (
    input  set, d_in, en, dir, sat, limit, prescale, cmp_val, clr_ovf,
    output q_out, tc, cmp_match, ovf
  );
endinterface

// File: rtl/mod_counter.sv
// Loadable up/down counter with programmable limit, wrap/saturate mode,
// prescaler, compare output and sticky overflow flag.
module mod_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mod_counter_if.slave   bus
);

  logic [WIDTH-1:0]      q;
  logic [PRESCALE_W-1:0] pcnt;
  logic                  tc_r;
  logic                  ovf_r;

  logic                  step;
  logic                  bound;
  logic [WIDTH-1:0]      q_nxt;

  // >= rather than == so lowering prescale mid-period steps right away.
  assign step = bus.en && !bus.set && (pcnt >= bus.prescale);

  always_comb begin
    bound = 1'b0;
    q_nxt = q;
    if (bus.dir) begin
      if (q < bus.limit) begin
        q_nxt = q + 1'b1;
      end else begin
        bound = 1'b1;
        q_nxt = bus.sat ? bus.limit : '0;
      end
    end else begin
      if (q != '0) begin
        q_nxt = q - 1'b1;
      end else begin
        bound = 1'b1;
        q_nxt = bus.sat ? '0 : bus.limit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      pcnt <= '0;
      tc_r <= 1'b0;
    end else if (bus.set) begin
      q    <= bus.d_in;
      pcnt <= '0;
      tc_r <= 1'b0;
    end else if (bus.en) begin
      if (step) begin
        q    <= q_nxt;
        pcnt <= '0;
        tc_r <= bound;
      end else begin
        pcnt <= pcnt + 1'b1;
        tc_r <= 1'b0;
      end
    end else begin
      tc_r <= 1'b0;
    end
  end

  // A bound event beats a simultaneous clear so no overflow is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ovf_r <= 1'b0;
    else if (step && bound)  ovf_r <= 1'b1;
    else if (bus.clr_ovf)    ovf_r <= 1'b0;
  end

  assign bus.q_out     = q;
  assign bus.tc        = tc_r;
  assign bus.ovf       = ovf_r;
  assign bus.cmp_match = (q == bus.cmp_val);

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: vector table, directed corner sequences and
// randomized traffic against an integer-arithmetic reference model.
module tb_mod_counter;

  localparam int W  = 8;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  int m_q, m_p, m_tc, m_ovf;

  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

  mod_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic          set;
    logic [W-1:0]  d_in;
    logic          en;
    logic          dir;
    logic          sat;
    logic [W-1:0]  limit;
    logic          clr_ovf;
    logic [W-1:0]  eq;
    logic          etc;
    logic          eovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic [W-1:0] d, logic e, logic dr, logic st,
                              logic [W-1:0] lim, logic clr, logic [W-1:0] q,
                              logic t, logic o);
    vec_t v;
    v.set = s; v.d_in = d; v.en = e; v.dir = dr; v.sat = st; v.limit = lim;
    v.clr_ovf = clr; v.eq = q; v.etc = t; v.eovf = o;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_p = 0; m_tc = 0; m_ovf = 0;
  endtask

  // Behavioural next state from the counting rules, using signed int math.
  task automatic model_step();
    int t;
    bit b;
    b = 0;
    if (bus.set) begin
      m_q = int'(bus.d_in); m_p = 0; m_tc = 0;
    end else if (bus.en) begin
      if (m_p >= int'(bus.prescale)) begin
        m_p = 0;
        t = bus.dir ? m_q + 1 : m_q - 1;
        b = bus.dir ? (t > int'(bus.limit)) : (t < 0);
        if (b) m_q = bus.sat ? (bus.dir ? int'(bus.limit) : 0)
                             : (bus.dir ? 0 : int'(bus.limit));
        else   m_q = t;
        m_tc = b;
      end else begin
        m_p++; m_tc = 0;
      end
    end else begin
      m_tc = 0;
    end
    if (b) m_ovf = 1;
    else if (bus.clr_ovf) m_ovf = 0;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".q"},   int'(bus.q_out), m_q);
    chk({tag, ".tc"},  int'(bus.tc), m_tc);
    chk({tag, ".ovf"}, int'(bus.ovf), m_ovf);
    chk({tag, ".cmp"}, int'(bus.cmp_match), int'(m_q == int'(bus.cmp_val)));
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic drive(logic s, logic [W-1:0] d, logic e, logic dr, logic st,
                       logic [W-1:0] lim, logic [PW-1:0] ps, logic clr);
    bus.set = s; bus.d_in = d; bus.en = e; bus.dir = dr; bus.sat = st;
    bus.limit = lim; bus.prescale = ps; bus.clr_ovf = clr;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 1, 0, 8'd9, 0, 0);
    bus.cmp_val = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.q", int'(bus.q_out), 0);
    chk("reset.tc", int'(bus.tc), 0);
    chk("reset.ovf", int'(bus.ovf), 0);
    chk("reset.cmp", int'(bus.cmp_match), 1);
    rst_n = 1'b1;
    bus.cmp_val = 8'd9;

    //       set d     en dir sat lim    clr  q      tc ovf
    vecs.push_back(mk(1, 8'h5A, 0, 1, 0, 8'd9, 0, 8'h5A, 0, 0));
    vecs.push_back(mk(1, 8'h07, 1, 1, 0, 8'd9, 0, 8'h07, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 8'd9, 0, 8'h08, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 8'd9, 0, 8'h09, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 8'd9, 0, 8'h00, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 8'd9, 0, 8'h01, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 8'd9, 1, 8'h01, 0, 0));
    vecs.push_back(mk(1, 8'h02, 0, 0, 1, 8'd9, 0, 8'h02, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'd9, 0, 8'h01, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'd9, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'd9, 0, 8'h00, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'd9, 0, 8'h00, 1, 1));
    vecs.push_back(mk(1, 8'hC8, 0, 1, 0, 8'd9, 0, 8'hC8, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 8'd9, 0, 8'h00, 1, 1));
    vecs.push_back(mk(1, 8'hC8, 0, 1, 1, 8'd9, 0, 8'hC8, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 8'd9, 0, 8'h09, 1, 1));
    vecs.push_back(mk(1, 8'hC8, 0, 0, 0, 8'd9, 0, 8'hC8, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'd9, 0, 8'hC7, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 8'hC7, 1, 8'hC7, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 8'hC7, 1, 8'hC7, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 1, 0, 8'd0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 8'd0, 0, 8'h00, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'd0, 0, 8'h00, 1, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].set, vecs[i].d_in, vecs[i].en, vecs[i].dir, vecs[i].sat,
            vecs[i].limit, 0, vecs[i].clr_ovf);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.q", i), int'(bus.q_out), int'(vecs[i].eq));
      chk($sformatf("vec%0d.tc", i), int'(bus.tc), int'(vecs[i].etc));
      chk($sformatf("vec%0d.ovf", i), int'(bus.ovf), int'(vecs[i].eovf));
      chk($sformatf("vec%0d.cmp", i), int'(bus.cmp_match), int'(vecs[i].eq == 8'd9));
    end

    // Prescaler: one step every 4 enabled cycles
    drive(1, 0, 0, 1, 0, 8'hFF, 4'd3, 0);
    tick("ps.load");
    drive(0, 0, 1, 1, 0, 8'hFF, 4'd3, 0);
    repeat (3) tick("ps.wait");
    chk("ps.hold", int'(bus.q_out), 0);
    tick("ps.step");
    chk("ps.step1", int'(bus.q_out), 1);
    // two enabled cycles, pause two, then two more to reach the step
    repeat (2) tick("ps.a");
    bus.en = 0;
    repeat (2) tick("ps.pause");
    bus.en = 1;
    tick("ps.b");
    chk("ps.ext", int'(bus.q_out), 1);
    tick("ps.c");
    chk("ps.step2", int'(bus.q_out), 2);
    // lower prescale to 0 while pcnt=2
    repeat (2) tick("ps.d");
    bus.prescale = 0;
    tick("ps.drop");
    chk("ps.drop", int'(bus.q_out), 3);

    // Async reset mid-count with no clock edge
    bus.cmp_val = 8'd0;
    @(posedge clk);
    model_step();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("areset.q", int'(bus.q_out), 0);
    chk("areset.tc", int'(bus.tc), 0);
    chk("areset.ovf", int'(bus.ovf), 0);
    chk("areset.cmp", int'(bus.cmp_match), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    bus.cmp_val = 8'd5;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.set      = ($urandom_range(0, 29) == 0);
      bus.d_in     = 8'($urandom);
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.dir      = ($urandom_range(0, 4) != 0);
      bus.sat      = ($urandom_range(0, 7) == 0) ? ~bus.sat : bus.sat;
      if ($urandom_range(0, 49) == 0)
        bus.limit = (r == 0) ? 8'd0 : (r == 1) ? 8'hFF : 8'($urandom_range(1, 40));
      bus.prescale = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 3)) : bus.prescale;
      bus.clr_ovf  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) bus.cmp_val = 8'($urandom_range(0, 12));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
Parametrised, loadable up/down counter with a programmable terminal value, a wrap or saturate mode, a count prescaler, a compare output and a sticky overflow flag. It is the general-purpose successor to the fixed 8-bit load/increment counter. It is used for timers, PWM periods and event counting in the control fabric. All state lives in one clock domain.

Parameters:
WIDTH, 8, counter, d_in, limit and cmp_val width (>=2)
PRESCALE_W, 4, width of prescale field and internal prescaler counter (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
set  in  1  synchronous load of d_in; overrides en
d_in  in  WIDTH  load value
en  in  1  count enable (feeds prescaler)
dir  in  1  1 = count up, 0 = count down
sat  in  1  1 = saturate at bounds, 0 = wrap
limit  in  WIDTH  upper bound; count range is 0..limit
prescale  in  PRESCALE_W  one step per (prescale+1) enabled cycles
cmp_val  in  WIDTH  compare value
clr_ovf  in  1  synchronous clear of ovf
q_out  out  WIDTH  current count (registered)
tc  out  1  one-cycle terminal pulse (registered)
cmp_match  out  1  combinational, (q_out == cmp_val)
ovf  out  1  sticky overflow/underflow flag (registered)

Behaviour:
- Reset (rst_n low, asynchronous): q_out=0, prescaler=0, tc=0, ovf=0. cmp_match follows q_out==cmp_val, so it is 1 when cmp_val==0.
- Priority per cycle: set > en > hold. All inputs are sampled on the rising clk edge.
- set=1: q_out<=d_in (not clamped, even if d_in>limit); prescaler<=0; tc<=0; no ovf event.
- en=1, set=0, prescaler: if pcnt>=prescale then step the counter and pcnt<=0, else pcnt<=pcnt+1 with no step. The >= comparison handles prescale being lowered mid-count. prescale=0 gives one step per enabled cycle.
- en=0: pcnt and q_out hold; tc<=0.
- Up step (dir=1), when q_out<limit: q_out+1.
- Up step (dir=1), when q_out>=limit: wrap mode sets q_out<=0; saturate mode sets q_out<=limit. Both are bound events.
- Down step (dir=0), when q_out>0: q_out-1. This includes q_out>limit after a set; the counter simply decrements.
- Down step (dir=0), when q_out==0: wrap mode sets q_out<=limit; saturate mode holds 0. Both are bound events.
- Bound event: tc<=1 for exactly the cycle in which the new q_out is visible, and ovf<=1. tc<=0 on every other cycle, including non-step enabled cycles.
- ovf: set on a bound event, cleared by clr_ovf. If both happen in the same cycle, set wins.
- limit=0: every step is a bound event and q_out stays 0. tc pulses on each step.
- limit={WIDTH{1'b1}}: natural modulo-2^WIDTH behaviour.
- Arithmetic is unsigned, WIDTH bits; there are no carries beyond WIDTH.
- dir, sat and limit may change any cycle; they take effect on the next step.
- Latency: step to q_out is 1 cycle; tc and ovf are coincident with the updated q_out.
- Reset asserted mid-count immediately clears all state. After release, counting resumes from 0 with pcnt=0.

Test Plan:
- Reset/load (WIDTH=8): rst_n low -> q_out=0, tc=0, ovf=0; release, then set=1, d_in=0x5A for one cycle -> q_out=0x5A next cycle; set with en=1 -> load wins.
- Wrap up: limit=9, sat=0, dir=1, prescale=0, en=1 from q=0 -> q_out 1..9, then 0 with tc=1 for one cycle and ovf=1; clr_ovf=1 -> ovf=0 next cycle.
- Saturate down: sat=1, dir=0, load 2 -> q_out 1, 0, 0, 0; tc pulses on each blocked step; ovf=1; q_out never reaches 0xFF or limit.
- Prescaler: prescale=3, en=1 continuous -> q_out increments every 4th cycle. Drop en for 2 cycles mid-period -> period is extended by exactly 2 cycles. Change prescale to 0 while pcnt=2 -> step on the next enabled cycle.
- Out-of-range load: limit=9, load 200, dir=1, sat=0 -> next step gives q_out=0 with tc=1. With sat=1 -> q_out=9. With dir=0 -> q_out=199, no tc.
- Compare/overflow race: cmp_val=5 -> cmp_match high exactly while q_out==5. A bound event in the same cycle as clr_ovf=1 -> ovf=1. Async reset mid-count -> outputs clear with no clk edge required.
